// File: rtl/fetch_aligner.sv
// RV32IC fetch front end: reads 32-bit words from the I-cache, splits them into
// 16/32-bit instructions (including word-straddling ones) and hands them to decode.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        proc_reset_n,
  output logic        icache_read,
  output logic [29:0] icache_addr,
  input  logic [31:0] icache_rdata,
  input  logic        icache_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_compressed
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 30;
  localparam int unsigned HW   = 16;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [HW-1:0]     r_hold;
  logic              r_hold_vld;
  logic              r_pend;
  logic [XLEN-1:0]   r_pend_pc;
  logic              r_active;
  logic              r_inst_valid;
  logic [XLEN-1:0]   r_inst;
  logic [XLEN-1:0]   r_inst_pc;
  logic              r_inst_c;

  state_t            w_state;
  logic [XLEN-1:0]   w_pc;
  logic [HW-1:0]     w_hold;
  logic              w_hold_vld;
  logic              w_pend;
  logic [XLEN-1:0]   w_pend_pc;
  logic [XLEN-1:0]   w_tgt;
  logic              w_read;
  logic [AW-1:0]     w_addr;
  logic              w_load;
  logic [XLEN-1:0]   w_ld_inst;
  logic              w_ld_c;
  logic              w_flush;
  logic              w_slot_free;
  logic              w_hold_c;
  logic              w_lo_c;

  assign w_slot_free = !r_inst_valid || inst_ready;
  assign w_hold_c    = (r_hold[1:0] != 2'b11);
  assign w_lo_c      = (icache_rdata[1:0] != 2'b11);

  // Fetch request, alignment and redirect handling
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_hold     = r_hold;
    w_hold_vld = r_hold_vld;
    w_pend     = r_pend;
    w_pend_pc  = r_pend_pc;
    w_tgt      = r_pend_pc;
    w_read     = 1'b0;
    w_addr     = r_pc[XLEN-1:2];
    w_load     = 1'b0;
    w_ld_inst  = '0;
    w_ld_c     = 1'b0;
    w_flush    = 1'b0;

    // Request depends only on frozen state while stalled, so it holds steady
    if (r_active) begin
      case (r_state)
        S_RUN: begin
          if (!r_pc[1]) begin
            w_read = w_slot_free;
          end else if (r_hold_vld && !w_hold_c) begin
            w_read = w_slot_free;
            w_addr = r_pc[XLEN-1:2] + AW'(1);
          end
        end
        S_FILL:  w_read = w_slot_free;
        default: w_read = 1'b0;
      endcase
    end

    if (icache_stall) begin
      if (redirect) begin
        w_pend    = 1'b1;
        w_pend_pc = redirect_pc;
        w_flush   = 1'b1;
      end
    end else if (redirect || r_pend) begin
      w_tgt      = redirect ? redirect_pc : r_pend_pc;
      w_pc       = w_tgt & ~XLEN'(1);
      w_hold_vld = 1'b0;
      w_pend     = 1'b0;
      w_flush    = 1'b1;
      w_state    = w_tgt[1] ? S_FILL : S_RUN;
    end else if (r_active) begin
      case (r_state)
        S_RUN: begin
          if (!r_pc[1]) begin
            if (w_slot_free) begin
              w_load = 1'b1;
              if (w_lo_c) begin
                w_ld_inst  = {16'h0000, icache_rdata[15:0]};
                w_ld_c     = 1'b1;
                w_pc       = r_pc + XLEN'(2);
                w_hold     = icache_rdata[31:16];
                w_hold_vld = 1'b1;
              end else begin
                w_ld_inst  = icache_rdata;
                w_pc       = r_pc + XLEN'(4);
                w_hold_vld = 1'b0;
              end
            end
          end else if (r_hold_vld) begin
            if (w_slot_free) begin
              w_load = 1'b1;
              if (w_hold_c) begin
                w_ld_inst  = {16'h0000, r_hold};
                w_ld_c     = 1'b1;
                w_pc       = r_pc + XLEN'(2);
                w_hold_vld = 1'b0;
              end else begin
                // Instruction straddles the word boundary
                w_ld_inst  = {icache_rdata[15:0], r_hold};
                w_pc       = r_pc + XLEN'(4);
                w_hold     = icache_rdata[31:16];
                w_hold_vld = 1'b1;
              end
            end
          end else begin
            w_state = S_FILL;
          end
        end
        S_FILL: begin
          if (w_slot_free) begin
            w_hold     = icache_rdata[31:16];
            w_hold_vld = 1'b1;
            w_state    = S_RUN;
          end
        end
        default: w_state = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC & ~XLEN'(1);
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_pc  <= '0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_hold     <= w_hold;
      r_hold_vld <= w_hold_vld;
      r_pend     <= w_pend;
      r_pend_pc  <= w_pend_pc;
      r_active   <= 1'b1;
    end
  end

  // Output register toward decode
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_c     <= 1'b0;
    end else if (w_flush) begin
      r_inst_valid <= 1'b0;
    end else if (w_load) begin
      r_inst_valid <= 1'b1;
      r_inst       <= w_ld_inst;
      r_inst_pc    <= r_pc;
      r_inst_c     <= w_ld_c;
    end else if (inst_ready) begin
      r_inst_valid <= 1'b0;
    end
  end

  assign icache_read        = w_read;
  assign icache_addr        = w_addr;
  assign inst_valid         = r_inst_valid;
  assign inst               = r_inst;
  assign inst_pc            = r_inst_pc;
  assign inst_is_compressed = r_inst_c;

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: directed scenarios plus random traffic checked against
// an instruction-stream model that walks memory halfword by halfword.
module tb_fetch_aligner;

  logic        clk;
  logic        proc_reset_n;
  logic        icache_read;
  logic [29:0] icache_addr;
  logic [31:0] icache_rdata;
  logic        icache_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;

  logic [31:0] mem [256];
  int n_vec;
  int n_err;
  int n_acc;

  assign icache_rdata = mem[icache_addr[7:0]];

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .proc_reset_n       (proc_reset_n),
    .icache_read        (icache_read),
    .icache_addr        (icache_addr),
    .icache_rdata       (icache_rdata),
    .icache_stall       (icache_stall),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .inst_valid         (inst_valid),
    .inst_ready         (inst_ready),
    .inst               (inst),
    .inst_pc            (inst_pc),
    .inst_is_compressed (inst_is_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then settle before sampling
  task automatic step(input logic rdy, input logic stl, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    inst_ready   = rdy;
    icache_stall = stl;
    redirect     = rd;
    redirect_pc  = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    proc_reset_n = 1'b0;
    icache_stall = 1'b0;
    redirect     = 1'b0;
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b1;
    #1;
  endtask

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic c);
    check({tag, "_v"}, 32'(inst_valid), 32'd1);
    check({tag, "_pc"}, inst_pc, pc);
    check({tag, "_inst"}, inst, ins);
    check({tag, "_c"}, 32'(inst_is_compressed), 32'(c));
  endtask

  initial begin
    logic [31:0] exp_pc, exp_inst, p_addr, p_inst, p_pc;
    logic [15:0] h0;
    logic        exp_c, p_read, p_stall, p_valid, p_ready, p_redir, p_c;
    n_vec = 0; n_err = 0; n_acc = 0;
    proc_reset_n = 1'b0;
    inst_ready = 1'b1; icache_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset values
    mem[0] = 32'h0050_0093; mem[1] = 32'h4505_4501; mem[2] = 32'h0001_0001;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_c", 32'(inst_is_compressed), 32'd0);
    check("rst_read", 32'(icache_read), 32'd0);

    // Aligned word then two compressed halves
    do_reset();
    check("t1_c0_read", 32'(icache_read), 32'd0);
    step(1, 0, 0, 0);
    check("t1_rd0", 32'(icache_read), 32'd1);
    check("t1_addr0", 32'(icache_addr), 32'd0);
    step(1, 0, 0, 0);
    chk_out("t1_i0", 32'h0, 32'h0050_0093, 1'b0);
    check("t1_addr1", 32'(icache_addr), 32'd1);
    check("t1_rd1", 32'(icache_read), 32'd1);
    step(1, 0, 0, 0);
    chk_out("t1_i1", 32'h4, 32'h0000_4501, 1'b1);
    check("t1_noread", 32'(icache_read), 32'd0);
    step(1, 0, 0, 0);
    chk_out("t1_i2", 32'h6, 32'h0000_4505, 1'b1);

    // Straddling 32-bit instruction
    mem[0] = 32'h0093_4501; mem[1] = 32'h1234_0050;
    do_reset();
    step(1, 0, 0, 0);
    check("t2_addr0", 32'(icache_addr), 32'd0);
    step(1, 0, 0, 0);
    chk_out("t2_i0", 32'h0, 32'h0000_4501, 1'b1);
    check("t2_addr1", 32'(icache_addr), 32'd1);
    step(1, 0, 0, 0);
    chk_out("t2_i1", 32'h2, 32'h0050_0093, 1'b0);
    check("t2_noread", 32'(icache_read), 32'd0);
    step(1, 0, 0, 0);
    chk_out("t2_i2", 32'h6, 32'h0000_1234, 1'b1);

    // Backpressure: pc8 held for 3 cycles, then 0xA follows
    step(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk_out("t3_hold", 32'h8, 32'h0000_0001, 1'b1);
      check("t3_noread", 32'(icache_read), 32'd0);
      step(k == 2, 0, 0, 0);
    end
    chk_out("t3_last", 32'h8, 32'h0000_0001, 1'b1);
    step(1, 0, 0, 0);
    chk_out("t3_next", 32'hA, 32'h0000_0001, 1'b1);

    // Redirect to 0x102 through FILL
    mem[8'h40] = 32'h4501_0000; mem[8'h41] = 32'h0000_0001;
    step(1, 0, 1, 32'h0000_0102);
    step(1, 0, 0, 0);
    check("t4_flush", 32'(inst_valid), 32'd0);
    check("t4_fill_rd", 32'(icache_read), 32'd1);
    check("t4_fill_addr", 32'(icache_addr), 32'h40);
    step(1, 0, 0, 0);
    check("t4_gap", 32'(inst_valid), 32'd0);
    step(1, 0, 0, 0);
    chk_out("t4_i0", 32'h102, 32'h0000_4501, 1'b1);
    step(1, 0, 0, 0);
    chk_out("t4_i1", 32'h104, 32'h0000_0001, 1'b1);

    // Redirect during a miss
    mem[8'h10] = 32'h0001_0001; mem[8'h80] = 32'h0001_0001;
    step(1, 0, 1, 32'h0000_0040);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, k == 1, 32'h0000_0200);
      check("t5_rd", 32'(icache_read), 32'd1);
      check("t5_addr", 32'(icache_addr), 32'h10);
      check("t5_nov", 32'(inst_valid), 32'd0);
    end
    step(1, 0, 0, 0);
    check("t5_rel_addr", 32'(icache_addr), 32'h10);
    step(1, 0, 0, 0);
    check("t5_nov2", 32'(inst_valid), 32'd0);
    check("t5_new_addr", 32'(icache_addr), 32'h80);
    step(1, 0, 0, 0);
    chk_out("t5_i0", 32'h200, 32'h0000_0001, 1'b1);

    // Reset during a miss acts without a clock edge
    step(1, 0, 1, 32'h0000_0040);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("t6_pre_rd", 32'(icache_read), 32'd1);
    #2;
    proc_reset_n = 1'b0;
    #1;
    check("t6_async_rd", 32'(icache_read), 32'd0);
    check("t6_async_v", 32'(inst_valid), 32'd0);
    check("t6_async_pc", inst_pc, 32'd0);
    @(negedge clk);
    icache_stall = 1'b0;
    proc_reset_n = 1'b1;
    #1;
    step(1, 0, 0, 0);
    check("t6_first_addr", 32'(icache_addr), 32'd0);
    check("t6_first_rd", 32'(icache_read), 32'd1);

    // Random traffic against the instruction-stream model
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    exp_pc = 32'h0;
    p_read = 0; p_addr = '0; p_stall = 0; p_valid = 0; p_ready = 0; p_redir = 0;
    p_inst = '0; p_pc = '0; p_c = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 40) == 0,
           32'($urandom_range(0, 1023)));
      if (p_stall && p_read) begin
        check("r_stall_rd", 32'(icache_read), 32'd1);
        check("r_stall_addr", 32'(icache_addr), p_addr);
      end
      if (p_valid && !p_ready && !p_redir) begin
        check("r_bp_v", 32'(inst_valid), 32'd1);
        check("r_bp_pc", inst_pc, p_pc);
        check("r_bp_inst", inst, p_inst);
        check("r_bp_c", 32'(inst_is_compressed), 32'(p_c));
      end
      if (redirect) begin
        exp_pc = redirect_pc & ~32'd1;
      end else if (inst_valid && inst_ready) begin
        h0 = half_at(exp_pc);
        if (h0[1:0] != 2'b11) begin
          exp_inst = {16'h0, h0}; exp_c = 1'b1;
        end else begin
          exp_inst = {half_at(exp_pc + 32'd2), h0}; exp_c = 1'b0;
        end
        check("r_pc", inst_pc, exp_pc);
        check("r_inst", inst, exp_inst);
        check("r_c", 32'(inst_is_compressed), 32'(exp_c));
        exp_pc = exp_pc + (exp_c ? 32'd2 : 32'd4);
        n_acc++;
      end
      p_read = icache_read; p_addr = 32'(icache_addr); p_stall = icache_stall;
      p_valid = inst_valid; p_ready = inst_ready; p_redir = redirect;
      p_inst = inst; p_pc = inst_pc; p_c = inst_is_compressed;
    end
    check("r_progress", 32'(n_acc > 500), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
